// File: rtl/tree_acc_pkg.sv
// Shared helpers for the tree accumulator: saturating add, mode width and mode conventions.
package tree_acc_pkg;

  localparam int MODE_NONE = 0;

  typedef struct packed {
    logic               ovf;
    logic signed [63:0] sum;
  } sat_t;

  // Full reduction level for a given lane count.
  function automatic int mode_full(input int lanes);
    return $clog2(lanes);
  endfunction

  function automatic int mode_w(input int lanes);
    return $clog2($clog2(lanes) + 1);
  endfunction

  // Operands arrive sign-extended to 64 bits and are clamped to a signed w-bit range (w <= 62).
  function automatic sat_t sat_add(input logic signed [63:0] a,
                                   input logic signed [63:0] b,
                                   input int                 w);
    logic signed [63:0] s, mx, mn;
    sat_t r;
    s  = a + b;
    mx = (64'sd1 <<< (w - 1)) - 64'sd1;
    mn = -mx - 64'sd1;
    r.ovf = (s > mx) || (s < mn);
    r.sum = (s > mx) ? mx : (s < mn) ? mn : s;
    return r;
  endfunction

endpackage

// File: rtl/tree_accumulator_stage.sv
// One registered pairwise-add level of the reduction tree; sums grow one bit so they never wrap.
module adder_tree_stage #(
  parameter int N_IN   = 2,
  parameter int W_IN   = 16,
  parameter int MODE_W = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        adv,
  input  logic                        in_valid,
  input  logic                        in_last,
  input  logic [MODE_W-1:0]           in_mode,
  input  logic [N_IN-1:0][W_IN-1:0]   in_data,
  output logic                        out_valid,
  output logic                        out_last,
  output logic [MODE_W-1:0]           out_mode,
  output logic [N_IN/2-1:0][W_IN:0]   out_data
);

  logic [N_IN/2-1:0][W_IN:0] sum;

  always_comb begin
    sum = '0;
    for (int j = 0; j < N_IN/2; j++)
      sum[j] = (W_IN+1)'(signed'(in_data[2*j])) + (W_IN+1)'(signed'(in_data[2*j+1]));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_mode  <= '0;
      out_data  <= '0;
    end else if (adv) begin
      out_valid <= in_valid;
      out_last  <= in_last;
      out_mode  <= in_mode;
      out_data  <= sum;
    end
  end

endmodule

// File: rtl/tree_accumulator.sv
// Pipelined adder-tree reduction with per-group saturating accumulation and a ready/valid output.
module tree_accumulator
  import tree_acc_pkg::*;
#(
  parameter int LANES = 8,
  parameter int IN_W  = 16,
  parameter int ACC_W = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [LANES*IN_W-1:0]       in_data,
  input  logic [mode_w(LANES)-1:0]    in_mode,
  input  logic                        in_last,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [LANES*ACC_W-1:0]      out_data,
  output logic [mode_w(LANES)-1:0]    out_mode,
  output logic                        out_ovf
);

  localparam int LEVELS = mode_full(LANES);
  localparam int MODE_W = mode_w(LANES);

  typedef logic [LANES-1:0][ACC_W-1:0] lane_vec_t;

  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Mode is captured on the first beat of a group and reused for the rest of it.
  logic              in_open;
  logic [MODE_W-1:0] mode_q, mode_clamp, mode_eff;

  assign mode_clamp = (int'(in_mode) > LEVELS) ? MODE_W'(LEVELS) : in_mode;
  assign mode_eff   = in_open ? mode_q : mode_clamp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_open <= 1'b0;
      mode_q  <= '0;
    end else if (in_valid && adv) begin
      in_open <= !in_last;
      mode_q  <= mode_eff;
    end
  end

  // lvl[k] holds the level-k sums sign-extended to ACC_W, zero above LANES>>k.
  lane_vec_t         lvl     [LEVELS+1];
  lane_vec_t         tap_sel [LEVELS+1];
  lane_vec_t         tap_q   [1:LEVELS];
  logic [LEVELS:0]   v_l, last_l;
  logic [MODE_W-1:0] mode_l  [LEVELS+1];

  assign v_l[0]    = in_valid;
  assign last_l[0] = in_last;
  assign mode_l[0] = mode_eff;

  for (genvar i = 0; i < LANES; i++) begin : g_in
    assign lvl[0][i] = ACC_W'(signed'(in_data[i*IN_W +: IN_W]));
  end

  assign tap_sel[0] = (int'(mode_l[0]) == MODE_NONE) ? lvl[0] : '0;

  for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
    localparam int N_IN = LANES >> (k-1);
    localparam int W_IN = IN_W + k - 1;

    logic [N_IN-1:0][W_IN-1:0]  din;
    logic [N_IN/2-1:0][W_IN:0]  dout;

    for (genvar i = 0; i < N_IN; i++) begin : g_din
      assign din[i] = lvl[k-1][i][W_IN-1:0];
    end

    adder_tree_stage #(.N_IN(N_IN), .W_IN(W_IN), .MODE_W(MODE_W)) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .adv      (adv),
      .in_valid (v_l[k-1]),
      .in_last  (last_l[k-1]),
      .in_mode  (mode_l[k-1]),
      .in_data  (din),
      .out_valid(v_l[k]),
      .out_last (last_l[k]),
      .out_mode (mode_l[k]),
      .out_data (dout)
    );

    for (genvar j = 0; j < LANES; j++) begin : g_dout
      if (j < N_IN/2) begin : g_used
        assign lvl[k][j] = ACC_W'(signed'(dout[j]));
      end else begin : g_zero
        assign lvl[k][j] = '0;
      end
    end

    // The tapped vector travels alongside the tree so latency does not depend on mode.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   tap_q[k] <= '0;
      else if (adv) tap_q[k] <= tap_sel[k-1];
    end

    assign tap_sel[k] = (mode_l[k] == MODE_W'(k)) ? lvl[k] : tap_q[k];
  end

  lane_vec_t tap, acc, sum;
  logic      acc_open, acc_ovf, any_ovf;
  sat_t      r;

  assign tap = tap_sel[LEVELS];

  always_comb begin
    sum     = '0;
    any_ovf = 1'b0;
    r       = '0;
    for (int j = 0; j < LANES; j++) begin
      r = sat_add(acc_open ? 64'(signed'(acc[j])) : 64'sd0, 64'(signed'(tap[j])), ACC_W);
      sum[j]  = r.sum[ACC_W-1:0];
      any_ovf = any_ovf | r.ovf;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      acc_open  <= 1'b0;
      acc_ovf   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_mode  <= '0;
      out_ovf   <= 1'b0;
    end else if (adv) begin
      out_valid <= 1'b0;
      if (v_l[LEVELS]) begin
        if (last_l[LEVELS]) begin
          out_valid <= 1'b1;
          out_data  <= sum;
          out_mode  <= mode_l[LEVELS];
          out_ovf   <= acc_ovf | any_ovf;
          acc       <= '0;
          acc_open  <= 1'b0;
          acc_ovf   <= 1'b0;
        end else begin
          acc       <= sum;
          acc_open  <= 1'b1;
          acc_ovf   <= acc_ovf | any_ovf;
        end
      end
    end
  end

endmodule
